// File: rtl/pio_osr_autopull.sv
// rtl/pio_osr_autopull.sv - PIO output shift register with explicit PULL and autopull
module pio_osr_autopull (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_pull,
    input  logic        out_req,
    input  logic [5:0]  out_count,
    input  logic        shift_right,
    input  logic        autopull_en,
    input  logic [5:0]  pull_thresh,
    input  logic        pull_req,
    input  logic        pull_block,
    input  logic [31:0] x_reg,
    output logic [31:0] out_data,
    output logic        out_valid,
    output logic        stall,
    output logic [5:0]  shift_count
);

    logic [31:0] osr_q, osr_d;
    logic [5:0]  count_q, count_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;

    logic [5:0]  n;
    logic [5:0]  thresh;
    logic        need;
    logic [31:0] src;
    logic [31:0] slice;
    logic [31:0] remain;
    logic [6:0]  sum;
    logic        pull_c;
    logic        stall_c;

    // Decode shift width and threshold, and form the OUT slice from the selected source word.
    always_comb begin
        n      = (out_count == 6'd0 || out_count > 6'd32) ? 6'd32 : out_count;
        thresh = (pull_thresh == 6'd0 || pull_thresh > 6'd32) ? 6'd32 : pull_thresh;
        need   = autopull_en && (count_q >= thresh);
        // When a refill is due, the OUT consumes the fresh FIFO word in the same cycle.
        src    = need ? fifo_dout : osr_q;
        // Shifts by 32 naturally yield zero, covering the full-word case.
        if (shift_right) begin
            slice  = src & ~(32'hFFFF_FFFF << n);
            remain = src >> n;
        end else begin
            slice  = src >> (6'd32 - n);
            remain = src << n;
        end
        sum = {1'b0, count_q} + {1'b0, n};
    end

    // Next-state selection with priority OUT > PULL > background autopull.
    always_comb begin
        osr_d   = osr_q;
        count_d = count_q;
        data_d  = data_q;
        valid_d = 1'b0;
        pull_c  = 1'b0;
        stall_c = 1'b0;
        if (out_req) begin
            if (need && fifo_empty) begin
                stall_c = 1'b1;
            end else begin
                pull_c  = need;
                osr_d   = remain;
                data_d  = slice;
                valid_d = 1'b1;
                if (need) begin
                    count_d = n;
                end else if (sum > 7'd32) begin
                    count_d = 6'd32;
                end else begin
                    count_d = sum[5:0];
                end
            end
        end else if (pull_req) begin
            // A PULL while autopull is on and the OSR is not yet drained is a no-op.
            if (!(autopull_en && count_q < thresh)) begin
                if (!fifo_empty) begin
                    pull_c  = 1'b1;
                    osr_d   = fifo_dout;
                    count_d = 6'd0;
                end else if (pull_block) begin
                    stall_c = 1'b1;
                end else begin
                    osr_d   = x_reg;
                    count_d = 6'd0;
                end
            end
        end else if (need && !fifo_empty) begin
            pull_c  = 1'b1;
            osr_d   = fifo_dout;
            count_d = 6'd0;
        end
    end

    // State register; reset leaves the OSR empty (count 32) so autopull refills first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            osr_q   <= 32'd0;
            count_q <= 6'd32;
            data_q  <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            osr_q   <= osr_d;
            count_q <= count_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    // Combinational handshakes are suppressed during reset so no pop can occur.
    assign fifo_pull   = pull_c & reset_n;
    assign stall       = stall_c & reset_n;
    assign out_data    = data_q;
    assign out_valid   = valid_q;
    assign shift_count = count_q;

endmodule

// File: tb/tb_pio_osr_autopull.sv
// tb/tb_pio_osr_autopull.sv - self-checking bench for pio_osr_autopull
module tb_pio_osr_autopull;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_pull;
    logic        out_req;
    logic [5:0]  out_count;
    logic        shift_right;
    logic        autopull_en;
    logic [5:0]  pull_thresh;
    logic        pull_req;
    logic        pull_block;
    logic [31:0] x_reg;
    logic [31:0] out_data;
    logic        out_valid;
    logic        stall;
    logic [5:0]  shift_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] fq[$];

    longint unsigned m_osr;
    int              m_cnt;
    logic [31:0]     m_data;
    bit              m_valid;

    pio_osr_autopull dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .fifo_dout   (fifo_dout),
        .fifo_empty  (fifo_empty),
        .fifo_pull   (fifo_pull),
        .out_req     (out_req),
        .out_count   (out_count),
        .shift_right (shift_right),
        .autopull_en (autopull_en),
        .pull_thresh (pull_thresh),
        .pull_req    (pull_req),
        .pull_block  (pull_block),
        .x_reg       (x_reg),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .stall       (stall),
        .shift_count (shift_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sync_fifo();
        fifo_empty = (fq.size() == 0);
        fifo_dout  = (fq.size() == 0) ? 32'h0 : fq[0];
    endtask

    task automatic idle();
        out_req = 0; pull_req = 0; out_count = 0; shift_right = 1;
        pull_block = 0; x_reg = 0;
    endtask

    task automatic model_reset();
        m_osr = 0; m_cnt = 32; m_data = 0; m_valid = 0;
    endtask

    // One clock cycle: predict, check handshakes, clock, check registered outputs.
    task automatic cycle();
        int n, t;
        bit need, e_pull, e_stall, nv;
        longint unsigned s, p;
        sync_fifo();
        #1;
        n = (out_count == 0 || out_count > 32) ? 32 : int'(out_count);
        t = (pull_thresh == 0 || pull_thresh > 32) ? 32 : int'(pull_thresh);
        need = autopull_en && (m_cnt >= t);
        e_pull = 0; e_stall = 0; nv = 0;
        if (out_req) begin
            if (need && fq.size() == 0) begin
                e_stall = 1;
            end else begin
                s = need ? longint'(fq[0]) : m_osr;
                e_pull = need;
                p = 64'd1 << n;
                if (shift_right) begin
                    m_data = 32'(s % p);
                    m_osr  = s / p;
                end else begin
                    m_data = 32'(s / (64'd1 << (32 - n)));
                    m_osr  = (s * p) % (64'd1 << 32);
                end
                m_cnt = need ? n : ((m_cnt + n > 32) ? 32 : m_cnt + n);
                nv = 1;
            end
        end else if (pull_req) begin
            if (!(autopull_en && m_cnt < t)) begin
                if (fq.size() != 0) begin
                    e_pull = 1; m_osr = fq[0]; m_cnt = 0;
                end else if (pull_block) begin
                    e_stall = 1;
                end else begin
                    m_osr = x_reg; m_cnt = 0;
                end
            end
        end else if (need && fq.size() != 0) begin
            e_pull = 1; m_osr = fq[0]; m_cnt = 0;
        end
        m_valid = nv;
        check("fifo_pull", fifo_pull, e_pull);
        check("stall", stall, e_stall);
        @(posedge clk);
        #1;
        if (e_pull) void'(fq.pop_front());
        check("out_valid", out_valid, m_valid);
        check("out_data", out_data, m_data);
        check("shift_count", shift_count, m_cnt);
        sync_fifo();
    endtask

    initial begin
        reset_n = 0;
        idle();
        autopull_en = 0; pull_thresh = 0;
        model_reset();
        sync_fifo();
        repeat (2) @(posedge clk);
        #1;
        check("rst_shift_count", shift_count, 32);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_fifo_pull", fifo_pull, 0);
        check("rst_stall", stall, 0);
        reset_n = 1;

        // Autopull T=32, right shift bytes out of 0xDEADBEEF.
        autopull_en = 1; pull_thresh = 0;
        fq.push_back(32'hDEADBEEF);
        cycle();
        check("t2_count_after_pop", shift_count, 0);
        out_req = 1; out_count = 8; shift_right = 1;
        cycle(); check("t2_b0", out_data, 32'hEF);
        cycle(); check("t2_b1", out_data, 32'hBE);
        cycle(); check("t2_b2", out_data, 32'hAD);
        cycle(); check("t2_b3", out_data, 32'hDE);
        check("t2_count", shift_count, 32);

        // Left shift nibbles out of 0x12345678.
        idle();
        fq.push_back(32'h12345678);
        cycle();
        out_req = 1; out_count = 4; shift_right = 0;
        for (int i = 1; i <= 8; i++) begin
            cycle();
            check("t3_nibble", out_data, i);
        end
        idle(); autopull_en = 0;
        out_req = 1; out_count = 32;
        cycle(); check("t3_osr_zero", out_data, 0);

        // Autopull stall on empty FIFO, then same-cycle pop when a word arrives.
        idle(); autopull_en = 1;
        out_req = 1; out_count = 16; shift_right = 1;
        cycle(); check("t4_stall_valid", out_valid, 0);
        fq.push_back(32'hA5A50F0F);
        cycle();
        check("t4_data", out_data, 32'h0F0F);
        check("t4_count", shift_count, 16);

        // Blocking and non-blocking PULL with autopull off.
        idle(); autopull_en = 0;
        out_req = 1; out_count = 16; cycle();
        idle(); pull_req = 1; pull_block = 1;
        cycle(); cycle();
        pull_block = 0; x_reg = 32'h55;
        cycle(); check("t5_count", shift_count, 0);
        idle(); out_req = 1; out_count = 32;
        cycle(); check("t5_xdata", out_data, 32'h55);

        // Threshold 12 with 5-bit OUTs, then a full-word OUT.
        idle(); autopull_en = 1; pull_thresh = 12;
        fq.push_back(32'hFFFFFFFF);
        fq.push_back(32'h0BADF00D);
        cycle();
        out_req = 1; out_count = 5; shift_right = 1;
        cycle(); cycle(); cycle();
        check("t6_count15", shift_count, 15);
        out_count = 0;
        cycle();
        check("t6_word", out_data, 32'h0BADF00D);
        check("t6_count32", shift_count, 32);

        // Asynchronous reset mid-operation with a refill pending.
        idle(); autopull_en = 1; pull_thresh = 0;
        fq.push_back(32'hCAFEF00D);
        out_req = 1; out_count = 8;
        sync_fifo();
        #2;
        reset_n = 0;
        #1;
        check("mid_rst_pull", fifo_pull, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_count", shift_count, 32);
        @(posedge clk);
        #1;
        check("mid_rst_hold_pull", fifo_pull, 0);
        check("mid_rst_data", out_data, 0);
        reset_n = 1;
        model_reset();
        idle();

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            if (fq.size() < 4 && $urandom_range(0, 1) == 1) fq.push_back($urandom);
            out_req     = ($urandom_range(0, 9) < 4);
            pull_req    = ($urandom_range(0, 9) < 2);
            out_count   = 6'($urandom_range(0, 63));
            shift_right = 1'($urandom);
            autopull_en = ($urandom_range(0, 3) != 0);
            pull_thresh = 6'($urandom_range(0, 63));
            pull_block  = 1'($urandom);
            x_reg       = $urandom;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
